// File: rtl/ddr_lane_feeder_if.sv
// ---------------------------------------------------------------------------
// ddr_lane_feeder_if
//   Bundles the burst-control, memory-side and lane-side signals of one
//   ddr_lane_feeder instance.
//
//   Control : i_start, i_burst_len, o_busy, o_done
//   Memory  : i_mem_data, i_mem_valid, o_mem_ready   (valid/ready)
//   Lane    : o_ddr_data, o_ddr_valid, i_ddr_stall
//
//   Modports
//     slave  - the feeder itself (takes i_*, drives o_*)
//     master - whoever drives the feeder (memory reader / sequencer)
// ---------------------------------------------------------------------------
interface ddr_lane_feeder_if #(
  parameter int MEM_W  = 64,
  parameter int LANE_W = 16,
  parameter int LEN_W  = 10
) ();
  logic              i_start;
  logic [LEN_W-1:0]  i_burst_len;
  logic [MEM_W-1:0]  i_mem_data;
  logic              i_mem_valid;
  logic              o_mem_ready;
  logic [LANE_W-1:0] o_ddr_data;
  logic              o_ddr_valid;
  logic              i_ddr_stall;
  logic              o_busy;
  logic              o_done;

  modport slave (
    input  i_start, i_burst_len, i_mem_data, i_mem_valid, i_ddr_stall,
    output o_mem_ready, o_ddr_data, o_ddr_valid, o_busy, o_done
  );

  modport master (
    output i_start, i_burst_len, i_mem_data, i_mem_valid, i_ddr_stall,
    input  o_mem_ready, o_ddr_data, o_ddr_valid, o_busy, o_done
  );
endinterface

// File: rtl/ddr_lane_feeder.sv
// ---------------------------------------------------------------------------
// ddr_lane_feeder
//   Feeds one DLA DDR input lane. A burst of MEM_W-bit memory words is taken
//   over a valid/ready handshake into a FIFO_DEPTH-word FIFO, then each word
//   is down-converted into R = MEM_W/LANE_W beats (LSB beat first) and
//   presented on a registered lane output, one beat per non-stalled cycle.
//
//   Ports
//     clk      - single clock
//     i_reset  - synchronous, active-high reset
//     bus      - ddr_lane_feeder_if.slave:
//                i_start/i_burst_len : start a burst of i_burst_len words
//                i_mem_*/o_mem_ready : memory word handshake
//                o_ddr_*/i_ddr_stall : lane beat output, held while stalled
//                o_busy              : burst in progress
//                o_done              : 1-cycle pulse once a burst drained
//
//   MEM_W must be a multiple of LANE_W; FIFO_DEPTH a power of 2, >= 2.
//
//   Pipeline: FIFO -> shifter (holds one word) -> output register. A word
//   pushed at edge t reaches the shifter at t+1 and its first beat the
//   output register at t+2.
// ---------------------------------------------------------------------------
module ddr_lane_feeder #(
  parameter int MEM_W      = 64,
  parameter int LANE_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 10
) (
  input logic                 clk,
  input logic                 i_reset,
  ddr_lane_feeder_if.slave    bus
);

  localparam int R      = MEM_W / LANE_W;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;
  localparam int CNT_W  = $clog2(R + 1);
  localparam int BEAT_W = LEN_W + CNT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_in_q, rem_in_d;
  logic [BEAT_W-1:0]   beats_out_q, beats_out_d;

  logic [MEM_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   count_q, count_d;

  logic [MEM_W-1:0]    sh_data_q;
  logic [MEM_W-1:0]    sh_shifted;
  logic [CNT_W-1:0]    sh_cnt_q, sh_cnt_d;

  logic [LANE_W-1:0]   ddr_data_q, ddr_data_d;
  logic                ddr_valid_q, ddr_valid_d;

  logic                mem_ready;
  logic                busy;
  logic                done;
  logic                start_ok;
  logic                push;
  logic                pop;
  logic                out_load;
  logic                shift;
  logic                beat_taken;
  logic                drained;

  // -------------------------------------------------------------------------
  // Handshake / datapath control
  // -------------------------------------------------------------------------
  assign start_ok   = (state_q == ST_IDLE) && bus.i_start;
  assign push       = bus.i_mem_valid && mem_ready;
  // Output register may accept a new beat when it is empty or its current
  // beat is being taken this cycle.
  assign out_load   = !ddr_valid_q || !bus.i_ddr_stall;
  assign beat_taken = ddr_valid_q && !bus.i_ddr_stall;
  assign shift      = out_load && (sh_cnt_q != '0);
  // Refill the shifter when it is empty, or in the same cycle its last beat
  // moves to the output, so consecutive words stream without a bubble.
  assign pop        = (count_q != '0) &&
                      ((sh_cnt_q == '0) || ((sh_cnt_q == CNT_W'(1)) && out_load));
  // Nothing left upstream or buffered, and the beat in the output register
  // (if any) leaves this cycle.
  assign drained    = (rem_in_q == '0) && (count_q == '0) &&
                      (sh_cnt_q == '0) && out_load;

  // Shifter moves down by one lane; the vacated top lane fills with zero.
  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_shift
      if (gi == R - 1) begin : g_top
        assign sh_shifted[gi*LANE_W +: LANE_W] = '0;
      end else begin : g_mid
        assign sh_shifted[gi*LANE_W +: LANE_W] = sh_data_q[(gi+1)*LANE_W +: LANE_W];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = (bus.i_burst_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (drained) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: output decode
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    mem_ready = (state_q == ST_RUN) &&
                (count_q < FCNT_W'(FIFO_DEPTH)) &&
                (rem_in_q != '0);
  end

  // -------------------------------------------------------------------------
  // Counters, FIFO pointers, shifter occupancy and output register
  // -------------------------------------------------------------------------
  always_comb begin
    rem_in_d    = rem_in_q;
    beats_out_d = beats_out_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sh_cnt_d    = sh_cnt_q;
    ddr_data_d  = ddr_data_q;
    ddr_valid_d = ddr_valid_q;

    if (start_ok) begin
      rem_in_d    = bus.i_burst_len;
      beats_out_d = '0;
    end else begin
      if (push) begin
        rem_in_d = rem_in_q - LEN_W'(1);
      end
      if (beat_taken) begin
        beats_out_d = beats_out_q + BEAT_W'(1);
      end
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase

    if (out_load) begin
      if (sh_cnt_q != '0) begin
        ddr_data_d  = sh_data_q[LANE_W-1:0];
        ddr_valid_d = 1'b1;
        sh_cnt_d    = sh_cnt_q - CNT_W'(1);
      end else begin
        // Nothing to send: drop valid, keep the last data on the bus.
        ddr_valid_d = 1'b0;
      end
    end
    if (pop) begin
      sh_cnt_d = CNT_W'(R);
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      rem_in_q    <= '0;
      beats_out_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sh_cnt_q    <= '0;
      ddr_data_q  <= '0;
      ddr_valid_q <= 1'b0;
    end else begin
      rem_in_q    <= rem_in_d;
      beats_out_q <= beats_out_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sh_cnt_q    <= sh_cnt_d;
      ddr_data_q  <= ddr_data_d;
      ddr_valid_q <= ddr_valid_d;
    end
  end

  // FIFO storage with registered read into the shifter. Left unreset so it
  // maps onto RAM; sh_cnt_q alone decides whether the shifter holds data.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.i_mem_data;
    end
    if (pop) begin
      sh_data_q <= fifo_mem[rd_ptr_q];
    end else if (shift) begin
      sh_data_q <= sh_shifted;
    end
  end

  // -------------------------------------------------------------------------
  // Interface outputs
  // -------------------------------------------------------------------------
  assign bus.o_mem_ready = mem_ready;
  assign bus.o_ddr_data  = ddr_data_q;
  assign bus.o_ddr_valid = ddr_valid_q;
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;

endmodule

// File: tb/tb_ddr_lane_feeder.sv
// ---------------------------------------------------------------------------
// tb_ddr_lane_feeder
//   Directed bench for ddr_lane_feeder (MEM_W=64, LANE_W=16, FIFO_DEPTH=4).
//   A negedge monitor logs every taken beat, accepted word and done pulse;
//   the main sequence drives inputs 1 time unit after each rising edge and
//   compares the logs against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_ddr_lane_feeder;
  localparam int MEM_W      = 64;
  localparam int LANE_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 10;

  logic clk = 1'b0;
  logic i_reset;

  ddr_lane_feeder_if #(.MEM_W(MEM_W), .LANE_W(LANE_W), .LEN_W(LEN_W)) bus ();

  ddr_lane_feeder #(
    .MEM_W(MEM_W), .LANE_W(LANE_W), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- monitor ----------------
  int          cyc = 0;
  logic [15:0] beat_q[$];
  int          beat_cyc[$];
  int          acc_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          ready_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.o_ddr_valid && !bus.i_ddr_stall) begin
      beat_q.push_back(bus.o_ddr_data);
      beat_cyc.push_back(cyc);
      $display("[cyc %0d] beat  %0d = %h", cyc, beat_q.size() - 1, bus.o_ddr_data);
    end
    if (bus.i_mem_valid && bus.o_mem_ready) begin
      acc_cyc.push_back(cyc);
      $display("[cyc %0d] word  accepted = %h", cyc, bus.i_mem_data);
    end
    if (bus.o_done) begin
      done_cnt++;
      done_cyc = cyc;
      $display("[cyc %0d] done", cyc);
    end
    if (bus.o_mem_ready) ready_cnt++;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  logic [63:0] mem_words[16];
  int          idx = 0;
  logic        mem_en = 1'b0;
  logic [15:0] exp_q[$];

  task automatic tick();
    logic x;
    #3;
    x = bus.i_mem_valid && bus.o_mem_ready;
    @(posedge clk);
    #1;
    if (x && idx < 15) idx++;
    bus.i_mem_valid = mem_en;
    bus.i_mem_data  = mem_words[idx];
  endtask

  task automatic set_mem(input logic en);
    mem_en          = en;
    bus.i_mem_valid = en;
    bus.i_mem_data  = mem_words[idx];
  endtask

  task automatic start_burst(input int len);
    bus.i_start     = 1'b1;
    bus.i_burst_len = LEN_W'(len);
    tick();
    bus.i_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
  endtask

  task automatic check_beats(input string tag, input int b0);
    check({tag, "_beat_count"}, 64'(beat_q.size() - b0), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (b0 + i < beat_q.size())
        check($sformatf("%s_beat%0d", tag, i), 64'(beat_q[b0 + i]), 64'(exp_q[i]));
    end
  endtask

  task automatic run_len1(input string tag);
    int b0, a0, d0;
    mem_words[0] = 64'h4444_3333_2222_1111;
    mem_words[1] = 64'hDEAD_DEAD_DEAD_DEAD;
    idx = 0;
    set_mem(1'b1);
    b0 = beat_q.size(); a0 = acc_cyc.size(); d0 = done_cnt;
    start_burst(1);
    wait_done(tag, d0);
    set_mem(1'b0);
    repeat (3) tick();
    exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    check_beats(tag, b0);
    check({tag, "_words"}, 64'(acc_cyc.size() - a0), 64'd1);
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    if (beat_q.size() >= b0 + 4 && acc_cyc.size() > a0) begin
      check({tag, "_latency"}, 64'(beat_cyc[b0] - acc_cyc[a0]), 64'd3);
      check({tag, "_consecutive"}, 64'(beat_cyc[b0 + 3] - beat_cyc[b0]), 64'd3);
      check({tag, "_done_after_last"}, 64'(done_cyc - beat_cyc[b0 + 3]), 64'd1);
    end
    check({tag, "_idle_busy"}, 64'(bus.o_busy), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b0, a0, d0, r0;
    i_reset         = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_burst_len = '0;
    bus.i_mem_data  = '0;
    bus.i_mem_valid = 1'b0;
    bus.i_ddr_stall = 1'b0;
    for (int i = 0; i < 16; i++) mem_words[i] = '0;
    @(posedge clk); #1;
    tick(); tick();
    i_reset = 1'b0;

    // Reset state
    check("rst_ddr_valid", 64'(bus.o_ddr_valid), 64'd0);
    check("rst_ddr_data",  64'(bus.o_ddr_data),  64'd0);
    check("rst_mem_ready", 64'(bus.o_mem_ready), 64'd0);
    check("rst_busy",      64'(bus.o_busy),      64'd0);
    check("rst_done",      64'(bus.o_done),      64'd0);

    // 1: single word
    run_len1("t1");

    // 2: 8 words, memory always valid, no stall
    for (int k = 0; k < 16; k++)
      mem_words[k] = {16'(256 + 4*k + 3), 16'(256 + 4*k + 2), 16'(256 + 4*k + 1), 16'(256 + 4*k)};
    idx = 0;
    set_mem(1'b1);
    b0 = beat_q.size(); a0 = acc_cyc.size(); d0 = done_cnt;
    start_burst(8);
    wait_done("t2", d0);
    set_mem(1'b0);
    repeat (3) tick();
    exp_q = {};
    for (int j = 0; j < 32; j++) exp_q.push_back(16'(256 + j));
    check_beats("t2", b0);
    check("t2_words", 64'(acc_cyc.size() - a0), 64'd8);
    if (beat_q.size() >= b0 + 32)
      check("t2_gap_free", 64'(beat_cyc[b0 + 31] - beat_cyc[b0]), 64'd31);
    if (acc_cyc.size() >= a0 + 8) begin
      check("t2_full_throttle", 64'(acc_cyc[a0 + 5] - acc_cyc[a0 + 4]), 64'd2);
      check("t2_accept_span",   64'(acc_cyc[a0 + 7] - acc_cyc[a0]),     64'd14);
    end

    // 3: stall for 5 cycles while the second beat is presented
    mem_words[0] = 64'hDDDD_CCCC_BBBB_AAAA;
    mem_words[1] = 64'h8888_7777_6666_5555;
    mem_words[2] = 64'hEEEE_EEEE_EEEE_EEEE;
    idx = 0;
    set_mem(1'b1);
    b0 = beat_q.size(); d0 = done_cnt;
    start_burst(2);
    repeat (4) tick();
    bus.i_ddr_stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("t3_hold_data%0d", s),  64'(bus.o_ddr_data),  64'hBBBB);
      check($sformatf("t3_hold_valid%0d", s), 64'(bus.o_ddr_valid), 64'd1);
      if (s < 4) tick();
    end
    tick();
    bus.i_ddr_stall = 1'b0;
    wait_done("t3", d0);
    set_mem(1'b0);
    repeat (2) tick();
    exp_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD,
              16'h5555, 16'h6666, 16'h7777, 16'h8888};
    check_beats("t3", b0);

    // 4: zero-length burst
    set_mem(1'b1);
    r0 = ready_cnt; d0 = done_cnt;
    start_burst(0);
    check("t4_done_pulse", 64'(bus.o_done), 64'd1);
    check("t4_busy",       64'(bus.o_busy), 64'd0);
    tick();
    check("t4_done_clear", 64'(bus.o_done), 64'd0);
    tick();
    set_mem(1'b0);
    check("t4_ready_never", 64'(ready_cnt - r0), 64'd0);
    check("t4_done_count",  64'(done_cnt - d0), 64'd1);

    // 5: reset during the third beat of a 4-word burst
    for (int k = 0; k < 4; k++)
      mem_words[k] = {16'(16'h2000 + 4*k + 3), 16'(16'h2000 + 4*k + 2),
                      16'(16'h2000 + 4*k + 1), 16'(16'h2000 + 4*k)};
    idx = 0;
    set_mem(1'b1);
    d0 = done_cnt;
    start_burst(4);
    repeat (5) tick();
    check("t5_beat3_present", 64'(bus.o_ddr_data), 64'h2002);
    i_reset = 1'b1;
    tick();
    check("t5_rst_valid", 64'(bus.o_ddr_valid), 64'd0);
    check("t5_rst_data",  64'(bus.o_ddr_data),  64'd0);
    check("t5_rst_ready", 64'(bus.o_mem_ready), 64'd0);
    check("t5_rst_busy",  64'(bus.o_busy),      64'd0);
    check("t5_rst_done",  64'(bus.o_done),      64'd0);
    i_reset = 1'b0;
    set_mem(1'b0);
    b0 = beat_q.size();
    repeat (8) tick();
    check("t5_no_done",    64'(done_cnt - d0),        64'd0);
    check("t5_no_beats",   64'(beat_q.size() - b0),   64'd0);
    run_len1("t5_after");

    // 6: start pulse while busy is ignored
    mem_words[0] = 64'h1004_1003_1002_1001;
    mem_words[1] = 64'h1008_1007_1006_1005;
    for (int k = 2; k < 16; k++) mem_words[k] = 64'h5A5A_5A5A_5A5A_5A5A;
    idx = 0;
    set_mem(1'b1);
    b0 = beat_q.size(); a0 = acc_cyc.size(); d0 = done_cnt;
    start_burst(2);
    repeat (2) tick();
    bus.i_start     = 1'b1;
    bus.i_burst_len = LEN_W'(5);
    tick();
    bus.i_start     = 1'b0;
    wait_done("t6", d0);
    repeat (6) tick();
    set_mem(1'b0);
    exp_q = '{16'h1001, 16'h1002, 16'h1003, 16'h1004,
              16'h1005, 16'h1006, 16'h1007, 16'h1008};
    check_beats("t6", b0);
    check("t6_words",       64'(acc_cyc.size() - a0), 64'd2);
    check("t6_done_pulses", 64'(done_cnt - d0),       64'd1);
    check("t6_idle_busy",   64'(bus.o_busy),          64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
